// File: rtl/duck_flight_ctl.sv
// duck_flight_ctl: launches one duck, flies it in Q12.24 with edge bounces,
// and ends the round by shot (freeze, fall) or timeout (climb off the top).
// Ports: clk, rst (sync, high); start, hit in; xpos/ypos (12b px),
// duck_active, dog_enable (1-clk round-end pulse), result_hit out.
// Option: define DUCK_LFSR_EN for an 8-bit LFSR launch x and direction.
module duck_flight_ctl #(
  parameter int unsigned X_MIN      = 16,
  parameter int unsigned X_MAX      = 960,
  parameter int unsigned Y_TOP      = 16,
  parameter int unsigned Y_LOW      = 400,
  parameter int unsigned Y_GROUND   = 480,
  parameter int unsigned X_START    = 300,
  parameter logic [35:0] FLY_STEP   = 36'd60,
  parameter logic [35:0] FALL_STEP  = 36'd120,
  parameter logic [31:0] HIT_CYCLES = 32'd32_500_000,
  parameter logic [31:0] FLY_CYCLES = 32'd390_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hit,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        duck_active,
  output logic        dog_enable,
  output logic        result_hit
);

  typedef enum logic [2:0] {
    S_IDLE, S_FLY, S_HIT, S_FALL, S_ESC, S_DONE
  } state_t;

  localparam logic [35:0] X_RST = {12'd200, 24'd0};
  localparam logic [35:0] Y_OFF = {12'd700, 24'd0};
  localparam logic [35:0] Y_GND = {12'(Y_GROUND), 24'd0};

  state_t      state, state_n;
  logic [35:0] x_acc, x_n;
  logic [35:0] y_acc, y_n;
  logic        dx, dx_n;
  logic        dy, dy_n;
  logic [31:0] cnt, cnt_n;
  logic        res_n;
  logic [11:0] x_int, y_int;
  logic [11:0] launch_x;
  logic        launch_dx;

  assign x_int = x_acc[35:24];
  assign y_int = y_acc[35:24];

`ifdef DUCK_LFSR_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign launch_x  = 12'd100 + {3'b000, lfsr, 1'b0};
  assign launch_dx = lfsr[0];
`else
  assign launch_x  = 12'(X_START);
  assign launch_dx = 1'b0;
`endif

  always_comb begin
    state_n = state;
    x_n     = x_acc;
    y_n     = y_acc;
    dx_n    = dx;
    dy_n    = dy;
    cnt_n   = cnt;
    res_n   = result_hit;
    unique case (state)
      S_IDLE: begin
        y_n = Y_OFF;
        if (start) begin
          x_n     = {launch_x, 24'd0};
          y_n     = Y_GND;
          dx_n    = launch_dx;
          dy_n    = 1'b1;
          cnt_n   = '0;
          res_n   = 1'b0;
          state_n = S_FLY;
        end
      end
      S_FLY: begin
        x_n   = dx ? x_acc + FLY_STEP : x_acc - FLY_STEP;
        y_n   = dy ? y_acc - FLY_STEP : y_acc + FLY_STEP;
        cnt_n = cnt + 32'd1;
        // Flags flip from the pre-step position; the new
        // direction applies from the next step on.
        if (dx && x_int >= 12'(X_MAX)) dx_n = 1'b0;
        if (!dx && x_int <= 12'(X_MIN)) dx_n = 1'b1;
        if (dy && y_int <= 12'(Y_TOP)) dy_n = 1'b0;
        if (!dy && y_int >= 12'(Y_LOW)) dy_n = 1'b1;
        if (hit) begin
          cnt_n   = '0;
          state_n = S_HIT;
        end else if (cnt == FLY_CYCLES - 32'd1) begin
          cnt_n   = '0;
          state_n = S_ESC;
        end
      end
      S_HIT: begin
        cnt_n = cnt + 32'd1;
        if (cnt == HIT_CYCLES - 32'd1) state_n = S_FALL;
      end
      S_FALL: begin
        if (y_int >= 12'(Y_GROUND)) begin
          y_n     = Y_GND;
          res_n   = 1'b1;
          state_n = S_DONE;
        end else begin
          y_n = y_acc + FALL_STEP;
        end
      end
      S_ESC: begin
        if (y_int <= 12'(Y_TOP)) begin
          res_n   = 1'b0;
          state_n = S_DONE;
        end else begin
          y_n = y_acc - FALL_STEP;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      x_acc      <= X_RST;
      y_acc      <= Y_OFF;
      dx         <= 1'b0;
      dy         <= 1'b1;
      cnt        <= '0;
      result_hit <= 1'b0;
      xpos       <= 12'd200;
      ypos       <= 12'd700;
    end else begin
      state      <= state_n;
      x_acc      <= x_n;
      y_acc      <= y_n;
      dx         <= dx_n;
      dy         <= dy_n;
      cnt        <= cnt_n;
      result_hit <= res_n;
      xpos       <= x_int;
      ypos       <= y_int;
    end
  end

  assign duck_active = (state != S_IDLE);
  assign dog_enable  = (state == S_DONE);

endmodule

// File: tb/tb_duck_flight_ctl.sv
// tb_duck_flight_ctl: directed flights with a round-end scoreboard
// checked whenever dog_enable pulses.
module tb_duck_flight_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        hit;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        duck_active;
  logic        dog_enable;
  logic        result_hit;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        res;
    logic [11:0] x;
    logic [11:0] y;
    bit          chk_x;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  duck_flight_ctl #(
    .X_START    (300),
    .FLY_STEP   (36'h100_0000),
    .FALL_STEP  (36'h200_0000),
    .HIT_CYCLES (32'd10),
    .FLY_CYCLES (32'd2000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .hit         (hit),
    .xpos        (xpos),
    .ypos        (ypos),
    .duck_active (duck_active),
    .dog_enable  (dog_enable),
    .result_hit  (result_hit)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic r, input int x, input int y,
                      input bit cx);
    exp_t e;
    e.res   = r;
    e.x     = 12'(x);
    e.y     = 12'(y);
    e.chk_x = cx;
    q.push_back(e);
  endtask

  // Launch; returns after the first FLY edge with the launch x.
  task automatic launch(output logic [11:0] lx);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("launch_active", int'(duck_active), 1);
    @(negedge clk);
    chk("launch_ypos", int'(ypos), 480);
    lx = xpos;
`ifndef DUCK_LFSR_EN
    chk("launch_xpos", int'(xpos), 300);
`endif
  endtask

  // Hit sampled on the k-th FLY edge (k >= 2).
  task automatic hit_at(input int k);
    repeat (k - 2) @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("round_timeout_pending", q.size(), 0);
    q.delete();
  endtask

  initial begin
    logic [11:0] lx;
    logic [11:0] first_x;
    bit          varied;
    bit          act_seen;
    rst   = 1'b1;
    start = 1'b0;
    hit   = 1'b0;

    fork
      begin : monitor
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
          @(negedge clk);
          if (!rst && dog_enable) begin
            chk("dog_width", int'(prev), 0);
            if (q.size() == 0) begin
              chk("dog_unexpected", 1, 0);
            end else begin
              e = q.pop_front();
              chk("result_hit", int'(result_hit), int'(e.res));
              chk("end_ypos", int'(ypos), int'(e.y));
              if (e.chk_x) chk("end_xpos", int'(xpos), int'(e.x));
            end
          end
          prev = dog_enable & ~rst;
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_xpos", int'(xpos), 200);
    chk("rst_ypos", int'(ypos), 700);
    chk("rst_active", int'(duck_active), 0);
    chk("rst_dog", int'(dog_enable), 0);
    chk("rst_result", int'(result_hit), 0);
    rst = 1'b0;

    act_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      hit = (i % 7 == 3);
      if (duck_active) act_seen = 1'b1;
    end
    hit = 1'b0;
    chk("idle_no_active", int'(act_seen), 0);
    chk("idle_xpos", int'(xpos), 200);
    chk("idle_ypos", int'(ypos), 700);

`ifndef DUCK_LFSR_EN
    // Shot on FLY edge 50: 50 px left and up from (300,480).
    launch(lx);
    hit_at(50);
    push(1'b1, 250, 480, 1'b1);
    @(negedge clk);
    chk("freeze_x", int'(xpos), 250);
    chk("freeze_y", int'(ypos), 430);
    repeat (10) @(negedge clk);
    chk("hold_y", int'(ypos), 430);
    chk("hold_active", int'(duck_active), 1);
    @(negedge clk);
    chk("fall_start_y", int'(ypos), 432);
    wait_done(200);
    repeat (3) @(negedge clk);
    chk("post_xpos", int'(xpos), 250);
    chk("post_ypos", int'(ypos), 700);
    chk("post_active", int'(duck_active), 0);
    chk("post_result", int'(result_hit), 1);

    // Timeout: after 2000 steps x=192 heading left, y=24;
    // escape climbs 2 px/clk to y=16.
    launch(lx);
    push(1'b0, 192, 16, 1'b1);
    wait_done(2500);
    chk("esc_result", int'(result_hit), 0);

    // Hit on the timeout edge wins.
    launch(lx);
    hit_at(2000);
    push(1'b1, 192, 480, 1'b1);
    wait_done(400);

    // Reset during FALL.
    launch(lx);
    hit_at(50);
    repeat (15) @(negedge clk);
    chk("pre_rst_active", int'(duck_active), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_xpos", int'(xpos), 200);
    chk("mid_rst_ypos", int'(ypos), 700);
    chk("mid_rst_active", int'(duck_active), 0);
    chk("mid_rst_dog", int'(dog_enable), 0);
    repeat (40) @(negedge clk);
    launch(lx);
    hit_at(50);
    push(1'b1, 250, 480, 1'b1);
    wait_done(200);
`else
    varied  = 1'b0;
    first_x = '0;
    for (int i = 0; i < 16; i++) begin
      launch(lx);
      chk("lfsr_x_range", int'(lx >= 12'd100 && lx <= 12'd610), 1);
      chk("lfsr_x_even", int'(lx[0]), 0);
      if (i == 0) first_x = lx;
      else if (lx != first_x) varied = 1'b1;
      hit_at(2);
      push(1'b1, 0, 480, 1'b0);
      wait_done(400);
      repeat (3) @(negedge clk);
    end
    chk("lfsr_x_varied", int'(varied), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
